dmem_responder: RTL and testbench

//   Data-memory responder: the memory-side end of the load/store path driven by
//   the main controller's dmem_w_en / store_load_sel decode. Accepts one request
//   at a time via valid/ready, performs RV32I byte/half/word stores and

---
 rtl/dmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the load/store path. Accepts one request
// at a time, performs RV32I byte/half/word stores and extended loads on an
// internal word array, and returns a response LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT occupies LATENCY-1 cycles; the counter runs down from LATENCY-2 to 0.
    localparam logic [CNT_W-1:0] WAIT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ready_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              handshake;
    logic [1:0]        size_code;
    logic              funct3_ok;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic [AW-1:0]     widx;
    logic [31:0]       word_rd;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              mem_we;

    assign accept    = req_valid && ready_q;
    assign handshake = (state == RESP) && rsp_ready;
    assign size_code = req_funct3[1:0];
    assign widx      = req_addr[AW+1:2];
    assign word_rd   = mem[widx];
    assign mem_we    = accept && req_we && !req_err;

    // Request decode: funct3 legality, natural alignment and word-index range.
    always_comb begin
        funct3_ok    = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        if (req_we) begin
            funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (size_code)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
        req_err      = !funct3_ok || misaligned || out_of_range;
    end

    // Store lane steering: replicate the right-aligned data and enable only the addressed lanes.
    always_comb begin
        wr_data = '0;
        wr_be   = '0;
        case (size_code)
            2'b00: begin
                wr_data = {4{req_wdata[7:0]}};
                wr_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wr_data = {2{req_wdata[15:0]}};
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = req_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    // Load lane selection and sign/zero extension; errors force zero data.
    always_comb begin
        shifted   = word_rd >> {req_addr[1:0], 3'b000};
        load_data = '0;
        case (req_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = word_rd;
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b101:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = '0;
        endcase
        if (req_err) begin
            load_data = '0;
        end
    end

    // Word array: stores commit on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: IDLE -> WAIT/RESP on accept, WAIT runs down, RESP waits for handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered ready (low throughout reset), latency counter and captured response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= (state_next == IDLE);
            if (accept) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (accept) begin
                rdata_q <= req_we ? '0 : load_data;
                err_q   <= req_err;
            end else if (handshake) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model with per-cycle output
// comparison, directed literal cases, then randomized traffic.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;
    localparam int BIG   = 1 << 30;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=none expected=event", name);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mb [DEPTH*4];
    int          cyc = 0;
    int          ready_from = BIG;
    int          acc_cyc = 0;
    bit          outstanding = 0;
    bit          in_reset = 1;
    logic [31:0] e_rdata = '0;
    logic        e_err = 1'b0;

    task automatic model_accept();
        int unsigned size;
        int unsigned a;
        bit          legal;
        logic [31:0] v;
        size  = (req_funct3[1:0] == 2'b00) ? 1 : (req_funct3[1:0] == 2'b01) ? 2 : 4;
        legal = req_we ? (req_funct3 <= 3'd2)
                       : (req_funct3 <= 3'd2 || req_funct3 == 3'd4 || req_funct3 == 3'd5);
        a     = req_addr;
        e_err = !legal || (a % size != 0) || ((a / 4) >= DEPTH);
        e_rdata = '0;
        if (!e_err) begin
            if (req_we) begin
                for (int i = 0; i < int'(size); i++) mb[a + i] = req_wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < int'(size); i++) v = v | (32'(mb[a + i]) << (8 * i));
                if (!req_funct3[2] && size < 4 && v[8*size - 1])
                    v = v | ~((32'h1 << (8 * size)) - 32'h1);
                e_rdata = v;
            end
        end
    endtask

    // Model update on each rising edge, output comparison on each falling edge.
    initial begin : model_and_compare
        bit pre_ready;
        bit pre_valid;
        forever begin
            @(posedge clk);
            cyc++;
            pre_ready = !in_reset && !outstanding && (cyc - 1) >= ready_from;
            pre_valid = outstanding && (cyc - 1) >= acc_cyc + LAT - 1;
            if (!rst_n) begin
                outstanding = 0;
                in_reset    = 1;
                ready_from  = BIG;
            end else begin
                if (pre_valid && rsp_ready) begin
                    outstanding = 0;
                    ready_from  = cyc;
                end else if (pre_ready && req_valid) begin
                    model_accept();
                    outstanding = 1;
                    acc_cyc     = cyc;
                end
                if (in_reset) begin
                    in_reset   = 0;
                    ready_from = cyc;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                check("reset_req_ready", 32'(req_ready), 32'd0);
                check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
                check("reset_rsp_rdata", rsp_rdata, 32'd0);
                check("reset_rsp_err", 32'(rsp_err), 32'd0);
            end else begin
                check("req_ready", 32'(req_ready),
                      32'(!in_reset && !outstanding && cyc >= ready_from));
                check("rsp_valid", 32'(rsp_valid),
                      32'(outstanding && cyc >= acc_cyc + LAT - 1));
                if (outstanding && cyc >= acc_cyc + LAT - 1) begin
                    check("rsp_rdata", rsp_rdata, e_rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e_err));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_garbage();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        rdata = '0;
        err   = 1'b0;
        lat   = 0;
        @(negedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        rsp_ready  = 1'b0;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!req_ready) begin
            fail_timeout("accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        lat = 1;
        drive_garbage();
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
            drive_garbage();
        end
        if (!rsp_valid) begin
            fail_timeout("response");
            req_valid = 1'b0;
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            drive_garbage();
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;
        logic [2:0]  f3;
        logic        we;
        int unsigned size;
        int unsigned widx;
        int unsigned off;
        logic [31:0] addr;
        logic [2:0]  load_codes [5];
        load_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(req_ready), 32'd1);

        // 1: word store/load
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
        check("t1_lw", rd, 32'hDEADBEEF);
        check("t1_err", 32'(er), 32'd0);
        // 2: byte store, signed/unsigned byte loads
        do_req(1, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
        do_req(1, 3'b000, 32'h11, 32'h80, 1, rd, er, lat);
        do_req(0, 3'b000, 32'h11, 32'h0, 0, rd, er, lat);
        check("t2_lb", rd, 32'hFFFFFF80);
        do_req(0, 3'b100, 32'h11, 32'h0, 2, rd, er, lat);
        check("t2_lbu", rd, 32'h00000080);
        do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
        check("t2_lw", rd, 32'h00008000);
        // 3: upper halfword store
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        do_req(1, 3'b001, 32'h12, 32'h00001234, 0, rd, er, lat);
        do_req(0, 3'b101, 32'h12, 32'h0, 0, rd, er, lat);
        check("t3_lhu", rd, 32'h00001234);
        do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
        check("t3_lw", rd, 32'h1234BEEF);
        // 4: error cases
        do_req(0, 3'b010, 32'h13, 32'h0, 0, rd, er, lat);
        check("t4_mis_lw_err", 32'(er), 32'd1);
        check("t4_mis_lw_data", rd, 32'h0);
        do_req(1, 3'b010, 32'h13, 32'h55555555, 0, rd, er, lat);
        check("t4_mis_sw_err", 32'(er), 32'd1);
        do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
        check("t4_word_kept", rd, 32'h1234BEEF);
        do_req(0, 3'b011, 32'h10, 32'h0, 0, rd, er, lat);
        check("t4_bad_funct3", 32'(er), 32'd1);
        do_req(0, 3'b010, 32'(DEPTH * 4), 32'h0, 0, rd, er, lat);
        check("t4_range_err", 32'(er), 32'd1);
        check("t4_range_data", rd, 32'h0);
        // 5: latency and held response
        do_req(0, 3'b010, 32'h10, 32'h0, 4, rd, er, lat);
        check("t5_latency", 32'(lat), 32'd3);
        check("t5_data", rd, 32'h1234BEEF);
        check("t5_ready_after_hs", 32'(req_ready), 32'd1);
        // 6: reset during WAIT after an accepted store
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!req_ready) fail_timeout("t6_accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rsp_valid_low", 32'(rsp_valid), 32'd0);
        check("t6_ready_low", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready_after_release", 32'(req_ready), 32'd1);
        do_req(0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat);
        check("t6_store_survived", rd, 32'hCAFEF00D);

        // Initialise every word so random loads see defined data.
        for (int w = 0; w < DEPTH; w++) do_req(1, 3'b010, 32'(w * 4), $urandom, 0, rd, er, lat);

        // Random traffic; the model checks every response.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8)
                f3 = we ? 3'($urandom_range(0, 2)) : load_codes[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            widx = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, DEPTH + 8)
                                               : $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 4) == 0) off = $urandom_range(0, 3);
            else off = size * $urandom_range(0, (4 / size) - 1);
            addr = ($urandom_range(0, 49) == 0) ? $urandom : 32'(widx * 4 + off);
            do_req(we, f3, addr, $urandom, $urandom_range(0, 3), rd, er, lat);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
